prga_fifo: RTL and testbench
============================

PRGA_FIFO -- requirements
Module: prga_fifo

Interface
REQ-001 Clocking SHALL be: reset rst, synchronous, active-high; clock clk.
REQ-002 Parameter DATA_WIDTH, default 32: width of din/dout.
REQ-003 Parameter DEPTH_LOG2, default 1: storage depth = 2**DEPTH_LOG2 entries.
REQ-004 Parameter LOOKAHEAD, default 0: 0 = registered-read FIFO, 1 = first-word-fall-through FIFO.
REQ-005 clk  input  1  clock, all state on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 full  output  1  storage holds 2**DEPTH_LOG2 entries.
REQ-008 wr  input  1  write request.
REQ-009 din  input  DATA_WIDTH  write data.
REQ-010 empty  output  1  no entry available to read.
REQ-011 rd  input  1  read request.
REQ-012 dout  output  DATA_WIDTH  read data.

Function
REQ-013 Write: wr && !full at edge N stores din at the write pointer and advances it; wr while full is ignored, no state change.
REQ-014 Read: rd && !empty at edge N advances the read pointer; rd while empty is ignored.
REQ-015 Simultaneous accepted write and read SHALL keep the occupancy unchanged; full gates the write independently of rd in the same cycle.
REQ-016 Pointers SHALL be DEPTH_LOG2+1 bits and wrap modulo 2**(DEPTH_LOG2+1).
REQ-017 empty SHALL equal (rd_ptr == wr_ptr); full SHALL equal (MSBs differ, lower bits equal); both derive from registered pointers.
REQ-018 A write at edge N SHALL deassert empty in the cycle after N.
REQ-019 LOOKAHEAD=0: dout SHALL be a register loaded with the head entry on the edge accepting rd && !empty, valid from the following cycle.
REQ-020 LOOKAHEAD=0: dout SHALL hold its value until the next accepted read.
REQ-021 LOOKAHEAD=1: dout SHALL combinationally show the head entry whenever !empty; rd && !empty consumes that value in the same cycle.
REQ-022 LOOKAHEAD=1: dout is don't-care while empty.
REQ-023 Data SHALL leave in write order, with no loss or duplication.

Reset
REQ-024 rst SHALL clear both pointers, giving empty=1 and full=0 in the cycle after the reset edge.
REQ-025 rst SHALL clear the LOOKAHEAD=0 dout register to 0.
REQ-026 rst asserted mid-operation SHALL discard all stored entries.
REQ-027 Storage contents are not reset.

Structure
REQ-028 No shared package is required; pointer width is a local constant.
REQ-029 Sub-module prga_fifo_lookahead_buffer SHALL be delivered alongside.
REQ-030 prga_fifo_lookahead_buffer parameters: DATA_WIDTH (default 32), REVERSED (default 0).
REQ-031 prga_fifo_lookahead_buffer ports: clk, rst, empty_i (in), rd_i (out), dout_i (in), empty (out), rd (in), dout (out).
REQ-032 REVERSED=0 converts an upstream LOOKAHEAD=0 FIFO into a lookahead interface using a valid register.
REQ-033 REVERSED=0: rd_i = !empty_i && (!valid || rd).
REQ-034 REVERSED=0: valid is set when rd_i is asserted and cleared on rd without refill; empty = !valid; dout = dout_i.
REQ-035 REVERSED=0: rst clears valid.
REQ-036 REVERSED=1 converts an upstream lookahead FIFO into a registered-read interface.
REQ-037 REVERSED=1: empty = empty_i; rd_i = rd.
REQ-038 REVERSED=1: dout register loads dout_i on rd && !empty_i and holds otherwise; rst clears it to 0.

Verification
REQ-039 Bench: DATA_WIDTH=8, stream 5A,F6,09,C4,81,E2,A0,7A; each cycle rd asserted with probability 1/3; cover four configurations (LOOKAHEAD=0; LOOKAHEAD=1; LOOKAHEAD=1 + buffer REVERSED=1; LOOKAHEAD=0 + buffer REVERSED=0).
REQ-040 Check, registered-read configurations: dout sampled one cycle after rd && !empty matches the stream in order.
REQ-041 Check, lookahead configurations: dout sampled in the rd && !empty cycle matches the stream in order.
REQ-042 Overflow: DEPTH_LOG2=1, write 5A,F6,09 with no reads -> full=1 after two writes, 09 dropped; reads return 5A then F6.
REQ-043 Underflow: rd on empty after reset -> pointers unchanged, empty stays 1; LOOKAHEAD=0 dout stays 00.
REQ-044 Fall-through: LOOKAHEAD=1, write C4 at edge N -> empty=0 and dout=C4 in cycle N+1 with no rd.
REQ-045 Mid-stream reset: 2 entries stored, pulse rst -> empty=1, full=0; next write 81 is read back as 81.

Source files
------------

// File: rtl/prga_fifo_pkg.sv
// Shared constants and helpers for the prga_fifo storage and its
// lookahead/registered-read adapter.
package prga_fifo_pkg;

   // Read-port styles selectable through the LOOKAHEAD parameter
   localparam int unsigned LA_REGISTERED  = 0;
   localparam int unsigned LA_FALLTHROUGH = 1;

   // One extra pointer bit separates the full and empty cases when the
   // index bits coincide.
   function automatic int unsigned ptr_width(input int unsigned depth_log2);
      return depth_log2 + 1;
   endfunction

endpackage

// File: rtl/prga_fifo_lookahead_buffer.sv
// Adapter between the two FIFO read styles.
// REVERSED=0: registered-read upstream -> lookahead (first-word-fall-through) downstream.
// REVERSED=1: lookahead upstream -> registered-read downstream.
module prga_fifo_lookahead_buffer import prga_fifo_pkg::*; #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned REVERSED   = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  empty_i,
   output logic                  rd_i,
   input  logic [DATA_WIDTH-1:0] dout_i,
   output logic                  empty,
   input  logic                  rd,
   output logic [DATA_WIDTH-1:0] dout
);

   if (REVERSED == 0) begin : gen_fwd
      logic valid_q, valid_d;

      // Prefetch whenever the holding slot is free or being consumed
      assign rd_i  = !empty_i && (!valid_q || rd);
      assign empty = !valid_q;
      assign dout  = dout_i;

      // Slot stays full on refill, drains on a read without refill
      always_comb begin
         valid_d = valid_q;
         if (rd_i)    valid_d = 1'b1;
         else if (rd) valid_d = 1'b0;
      end

      // Slot occupancy register
      always_ff @(posedge clk) begin
         if (rst) valid_q <= 1'b0;
         else     valid_q <= valid_d;
      end
   end else begin : gen_rev
      logic [DATA_WIDTH-1:0] dout_q;

      assign empty = empty_i;
      assign rd_i  = rd;
      assign dout  = dout_q;

      // Capture the fall-through head on the consuming edge
      always_ff @(posedge clk) begin
         if (rst)                 dout_q <= '0;
         else if (rd && !empty_i) dout_q <= dout_i;
      end
   end

endmodule

// File: rtl/prga_fifo.sv
// Synchronous FIFO with 2**DEPTH_LOG2 entries; registered-read or
// first-word-fall-through read port selected by LOOKAHEAD.
module prga_fifo import prga_fifo_pkg::*; #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH_LOG2 = 1,
   parameter int unsigned LOOKAHEAD  = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  full,
   input  logic                  wr,
   input  logic [DATA_WIDTH-1:0] din,
   output logic                  empty,
   input  logic                  rd,
   output logic [DATA_WIDTH-1:0] dout
);

   localparam int unsigned PTR_W   = ptr_width(DEPTH_LOG2);
   localparam int unsigned ENTRIES = 2 ** DEPTH_LOG2;

   logic [DATA_WIDTH-1:0] mem_q [ENTRIES];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2-1:0] wr_idx, rd_idx;
   logic                  wr_en, rd_en;

   assign wr_idx = wr_ptr_q[DEPTH_LOG2-1:0];
   assign rd_idx = rd_ptr_q[DEPTH_LOG2-1:0];

   // Flags come only from registered pointers
   assign empty = (rd_ptr_q == wr_ptr_q);
   assign full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) && (wr_idx == rd_idx);

   // Full gates the write regardless of a same-cycle read
   assign wr_en = wr && !full;
   assign rd_en = rd && !empty;

   // Pointer advance, wrapping naturally at 2**PTR_W
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
   end

   // Pointer registers; reset discards every stored entry
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage array, deliberately left unreset
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_idx] <= din;
   end

   if (LOOKAHEAD == LA_REGISTERED) begin : gen_reg_read
      logic [DATA_WIDTH-1:0] dout_q;

      // Load the head on the accepting edge and hold until the next read
      always_ff @(posedge clk) begin
         if (rst)        dout_q <= '0;
         else if (rd_en) dout_q <= mem_q[rd_idx];
      end

      assign dout = dout_q;
   end else begin : gen_fwft
      // Head entry is visible combinationally; meaningless while empty
      assign dout = mem_q[rd_idx];
   end

endmodule

// File: tb/tb_prga_fifo.sv
// Bench for prga_fifo: four read-port configurations driven in parallel,
// directed corner cases followed by a scoreboarded random-read stream.
module tb_prga_fifo;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] wr, rd, full, empty;
   logic [7:0] din  [4];
   logic [7:0] dout [4];

   logic       rd2_i, e2_i, rd3_i, e3_i;
   logic [7:0] d2_i, d3_i;

   int checks = 0;
   int errors = 0;

   logic [7:0] stream [8] = '{8'h5A, 8'hF6, 8'h09, 8'hC4, 8'h81, 8'hE2, 8'hA0, 8'h7A};
   logic [7:0] sb [4][$];

   always #5 clk = ~clk;

   // 0: registered read   1: lookahead
   // 2: lookahead FIFO + REVERSED=1 adapter (registered read)
   // 3: registered FIFO + REVERSED=0 adapter (lookahead)
   prga_fifo #(.DATA_WIDTH(8), .DEPTH_LOG2(1), .LOOKAHEAD(0)) u0 (
      .clk(clk), .rst(rst), .full(full[0]), .wr(wr[0]), .din(din[0]),
      .empty(empty[0]), .rd(rd[0]), .dout(dout[0]));
   prga_fifo #(.DATA_WIDTH(8), .DEPTH_LOG2(1), .LOOKAHEAD(1)) u1 (
      .clk(clk), .rst(rst), .full(full[1]), .wr(wr[1]), .din(din[1]),
      .empty(empty[1]), .rd(rd[1]), .dout(dout[1]));
   prga_fifo #(.DATA_WIDTH(8), .DEPTH_LOG2(1), .LOOKAHEAD(1)) u2 (
      .clk(clk), .rst(rst), .full(full[2]), .wr(wr[2]), .din(din[2]),
      .empty(e2_i), .rd(rd2_i), .dout(d2_i));
   prga_fifo_lookahead_buffer #(.DATA_WIDTH(8), .REVERSED(1)) b2 (
      .clk(clk), .rst(rst), .empty_i(e2_i), .rd_i(rd2_i), .dout_i(d2_i),
      .empty(empty[2]), .rd(rd[2]), .dout(dout[2]));
   prga_fifo #(.DATA_WIDTH(8), .DEPTH_LOG2(1), .LOOKAHEAD(0)) u3 (
      .clk(clk), .rst(rst), .full(full[3]), .wr(wr[3]), .din(din[3]),
      .empty(e3_i), .rd(rd3_i), .dout(d3_i));
   prga_fifo_lookahead_buffer #(.DATA_WIDTH(8), .REVERSED(0)) b3 (
      .clk(clk), .rst(rst), .empty_i(e3_i), .rd_i(rd3_i), .dout_i(d3_i),
      .empty(empty[3]), .rd(rd[3]), .dout(dout[3]));

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      wr  = '0;
      rd  = '0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int cyc;
      int wcnt [4];
      int rcnt [4];
      bit pend [4];
      bit done;
      bit r;
      logic [7:0] e;

      rst = 1'b1; wr = '0; rd = '0;
      for (int c = 0; c < 4; c++) din[c] = '0;
      @(negedge clk);
      do_reset();

      // Reset state
      chk("rst_empty", 8'(empty), 8'hF);
      chk("rst_full",  8'(full),  8'h0);
      chk("rst_dout0", dout[0], 8'h00);
      chk("rst_dout2", dout[2], 8'h00);

      // Underflow: read on empty
      rd = '1;
      @(negedge clk);
      rd = '0;
      chk("unf_empty", 8'(empty), 8'hF);
      chk("unf_full",  8'(full),  8'h0);
      chk("unf_dout0", dout[0], 8'h00);
      chk("unf_dout2", dout[2], 8'h00);

      // Fall-through: one write, no read
      wr[1:0] = 2'b11; din[0] = 8'hC4; din[1] = 8'hC4;
      @(negedge clk);
      wr = '0;
      chk("fwft_empty", 8'(empty[1]), 8'h0);
      chk("fwft_dout",  dout[1], 8'hC4);
      chk("reg_nodata", dout[0], 8'h00);
      do_reset();

      // Overflow on a two-entry FIFO
      wr[1:0] = 2'b11; din[0] = 8'h5A; din[1] = 8'h5A;
      @(negedge clk);
      din[0] = 8'hF6; din[1] = 8'hF6;
      @(negedge clk);
      chk("ovf_full0", 8'(full[0]), 8'h1);
      chk("ovf_full1", 8'(full[1]), 8'h1);
      din[0] = 8'h09; din[1] = 8'h09;
      @(negedge clk);
      wr = '0;
      chk("ovf_still_full", 8'(full[1:0]), 8'h3);
      chk("ovf_head1", dout[1], 8'h5A);
      rd[1:0] = 2'b11;
      @(negedge clk);
      chk("ovf_rd0_a", dout[0], 8'h5A);
      chk("ovf_rd1_b", dout[1], 8'hF6);
      chk("ovf_notfull", 8'(full[1:0]), 8'h0);
      @(negedge clk);
      rd = '0;
      chk("ovf_rd0_b", dout[0], 8'hF6);
      chk("ovf_drained", 8'(empty[1:0]), 8'h3);
      @(negedge clk);
      chk("ovf_hold0", dout[0], 8'hF6);
      chk("ovf_dropped", 8'(empty[1:0]), 8'h3);

      // Mid-stream reset discards stored entries
      do_reset();
      wr[1:0] = 2'b11; din[0] = 8'hE2; din[1] = 8'hE2;
      @(negedge clk);
      din[0] = 8'hA0; din[1] = 8'hA0;
      @(negedge clk);
      wr = '0;
      chk("mid_pre_full", 8'(full[1:0]), 8'h3);
      do_reset();
      chk("mid_empty", 8'(empty[1:0]), 8'h3);
      chk("mid_full",  8'(full[1:0]),  8'h0);
      wr[1:0] = 2'b11; din[0] = 8'h81; din[1] = 8'h81;
      @(negedge clk);
      wr = '0;
      chk("mid_head1", dout[1], 8'h81);
      rd[1:0] = 2'b11;
      @(negedge clk);
      rd = '0;
      chk("mid_rd0", dout[0], 8'h81);
      chk("mid_after", 8'(empty[1:0]), 8'h3);

      // Streamed traffic, random reads at ~1/3 probability
      do_reset();
      for (int c = 0; c < 4; c++) begin
         wcnt[c] = 0; rcnt[c] = 0; pend[c] = 1'b0;
      end
      cyc  = 0;
      done = 1'b0;
      while (!done && cyc < 600) begin
         for (int c = 0; c < 4; c++) begin
            // Registered-read outputs are valid one cycle after acceptance
            if ((c == 0 || c == 2) && pend[c]) begin
               if (sb[c].size() == 0) chk($sformatf("extra_rd%0d", c), dout[c], 8'hXX);
               else begin
                  e = sb[c].pop_front();
                  chk($sformatf("stream_reg%0d_%0d", c, rcnt[c]), dout[c], e);
               end
               rcnt[c]++;
            end
            r = ($urandom_range(2) == 0);
            rd[c] = r;
            // Lookahead outputs are checked in the consuming cycle
            if ((c == 1 || c == 3) && r && !empty[c]) begin
               if (sb[c].size() == 0) chk($sformatf("extra_rd%0d", c), dout[c], 8'hXX);
               else begin
                  e = sb[c].pop_front();
                  chk($sformatf("stream_la%0d_%0d", c, rcnt[c]), dout[c], e);
               end
               rcnt[c]++;
            end
            pend[c] = r && !empty[c];
            if (wcnt[c] < 8 && !full[c]) begin
               wr[c]  = 1'b1;
               din[c] = stream[wcnt[c]];
               sb[c].push_back(stream[wcnt[c]]);
               wcnt[c]++;
            end else begin
               wr[c] = 1'b0;
            end
         end
         @(negedge clk);
         cyc++;
         done = 1'b1;
         for (int c = 0; c < 4; c++) if (rcnt[c] < 8 || pend[c]) done = 1'b0;
      end
      wr = '0;
      rd = '0;
      for (int c = 0; c < 4; c++) chk($sformatf("stream_count%0d", c), 8'(rcnt[c]), 8'd8);
      @(negedge clk);
      chk("stream_end_empty", 8'(empty), 8'hF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
